// File: rtl/train_step_scheduler_if.sv
// Phase-command channel between the training-step scheduler and the PE-array mode FSM.
// cmd_valid stays high with cmd_phase/cmd_layer/cmd_stride held stable until a rising edge samples cmd_valid && cmd_ready.
interface train_step_scheduler_if #(
    parameter int LAYER_W = 2
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_phase;
    logic [LAYER_W-1:0] cmd_layer;
    logic               cmd_stride;
    logic               phase_done;

    modport master (
        output cmd_valid, cmd_phase, cmd_layer, cmd_stride,
        input  cmd_ready, phase_done
    );

    modport slave (
        input  cmd_valid, cmd_phase, cmd_layer, cmd_stride,
        output cmd_ready, phase_done
    );
endinterface

// File: rtl/train_step_scheduler.sv
// Sequences FP over all layers, then BP/WG from the last layer down, for iter_num iterations,
// issuing one phase command at a time and waiting for its phase_done.
module train_step_scheduler #(
    parameter int NUM_LAYERS = 4,
    parameter int LAYER_W    = 2,
    parameter int ITER_W     = 8
) (
    input  logic                   clk,
    input  logic                   sch_rst,
    input  logic                   start,
    input  logic [ITER_W-1:0]      iter_num,
    input  logic                   abort,
    input  logic                   cfg_we,
    input  logic [LAYER_W-1:0]     cfg_addr,
    input  logic                   cfg_stride,
    train_step_scheduler_if.master cmd_if,
    output logic                   busy,
    output logic                   done,
    output logic [ITER_W-1:0]      cur_iter,
    output logic                   err_unexp,
    output logic [1:0]             dbg_state
);
    localparam int SEQ_N = 3 * NUM_LAYERS;
    localparam int SEQ_W = (SEQ_N > 1) ? $clog2(SEQ_N) : 1;
    localparam logic [1:0] PH_FP = 2'b01;
    localparam logic [1:0] PH_BP = 2'b10;
    localparam logic [1:0] PH_WG = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                r_state;
    logic [SEQ_W-1:0]      r_seq;
    logic [ITER_W-1:0]     r_iter_num;
    logic [ITER_W-1:0]     r_cur_iter;
    logic [NUM_LAYERS-1:0] r_stride_tbl;
    logic                  r_abort_pend;
    logic                  r_cmd_valid;
    logic [1:0]            r_cmd_phase;
    logic [LAYER_W-1:0]    r_cmd_layer;
    logic                  r_cmd_stride;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_hs;
    logic                  w_last_cmd;
    logic                  w_iter_more;
    logic [SEQ_W-1:0]      w_nxt_seq;
    logic [1:0]            w_nxt_phase;
    logic [LAYER_W-1:0]    w_nxt_layer;
    logic [ITER_W:0]       w_iter_inc;
    int                    w_j;

    // Sequence index k: k < L is FP layer k; beyond that, pairs (BP, WG) walk layers downward.
    always_comb begin
        w_hs        = r_cmd_valid & cmd_if.cmd_ready;
        w_last_cmd  = (32'(r_seq) == SEQ_N - 1);
        w_nxt_seq   = r_seq + SEQ_W'(1);
        w_iter_inc  = {1'b0, r_cur_iter} + (ITER_W+1)'(1);
        w_iter_more = (w_iter_inc < {1'b0, r_iter_num});
        w_j         = 32'(w_nxt_seq) - NUM_LAYERS;
        if (w_j < 0) begin
            w_nxt_phase = PH_FP;
            w_nxt_layer = LAYER_W'(w_nxt_seq);
        end else begin
            w_nxt_phase = w_j[0] ? PH_WG : PH_BP;
            w_nxt_layer = LAYER_W'(NUM_LAYERS - 1 - w_j / 2);
        end
    end

    always_ff @(posedge clk or posedge sch_rst) begin
        if (sch_rst) begin
            r_state      <= S_IDLE;
            r_seq        <= '0;
            r_iter_num   <= '0;
            r_cur_iter   <= '0;
            r_stride_tbl <= '0;
            r_abort_pend <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_phase  <= 2'b00;
            r_cmd_layer  <= '0;
            r_cmd_stride <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_we && (32'(cfg_addr) < NUM_LAYERS))
                        r_stride_tbl[cfg_addr] <= cfg_stride;
                    if (start) begin
                        r_iter_num   <= iter_num;
                        r_cur_iter   <= '0;
                        r_err        <= 1'b0;
                        r_seq        <= '0;
                        r_abort_pend <= 1'b0;
                        r_busy       <= 1'b1;
                        if (iter_num == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_cmd_valid  <= 1'b1;
                            r_cmd_phase  <= PH_FP;
                            r_cmd_layer  <= '0;
                            r_cmd_stride <= r_stride_tbl[0];
                        end
                    end
                end
                S_ISSUE: begin
                    // An abort seen while stalled is remembered until the command is taken.
                    if (abort)
                        r_abort_pend <= 1'b1;
                    if (w_hs) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd_phase <= 2'b00;
                        if (abort || r_abort_pend) begin
                            r_state      <= S_FIN;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        r_state <= S_FIN;
                    end else if (cmd_if.phase_done) begin
                        if (!w_last_cmd) begin
                            r_seq        <= w_nxt_seq;
                            r_state      <= S_ISSUE;
                            r_cmd_valid  <= 1'b1;
                            r_cmd_phase  <= w_nxt_phase;
                            r_cmd_layer  <= w_nxt_layer;
                            r_cmd_stride <= r_stride_tbl[w_nxt_layer];
                        end else begin
                            r_cur_iter <= w_iter_inc[ITER_W-1:0];
                            if (w_iter_more) begin
                                r_seq        <= '0;
                                r_state      <= S_ISSUE;
                                r_cmd_valid  <= 1'b1;
                                r_cmd_phase  <= PH_FP;
                                r_cmd_layer  <= '0;
                                r_cmd_stride <= r_stride_tbl[0];
                            end else begin
                                r_state <= S_FIN;
                            end
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (cmd_if.phase_done && (r_state != S_WAIT))
                r_err <= 1'b1;
        end
    end

    assign cmd_if.cmd_valid  = r_cmd_valid;
    assign cmd_if.cmd_phase  = r_cmd_phase;
    assign cmd_if.cmd_layer  = r_cmd_layer;
    assign cmd_if.cmd_stride = r_cmd_stride;
    assign busy              = r_busy;
    assign done              = r_done;
    assign cur_iter          = r_cur_iter;
    assign err_unexp         = r_err;
    assign dbg_state         = r_state;
endmodule

// File: tb/tb_train_step_scheduler.sv
// Bench for train_step_scheduler: table-driven runs plus random runs checked against a command-list model.
module tb_train_step_scheduler;
    localparam int L  = 4;
    localparam int LW = 2;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          sch_rst;
    logic          start;
    logic [IW-1:0] iter_num;
    logic          abort;
    logic          cfg_we;
    logic [LW-1:0] cfg_addr;
    logic          cfg_stride;
    logic          busy;
    logic          done;
    logic [IW-1:0] cur_iter;
    logic          err_unexp;
    logic [1:0]    dbg_state;

    train_step_scheduler_if #(.LAYER_W(LW)) cmd_if ();

    train_step_scheduler #(.NUM_LAYERS(L), .LAYER_W(LW), .ITER_W(IW)) dut (
        .clk       (clk),
        .sch_rst   (sch_rst),
        .start     (start),
        .iter_num  (iter_num),
        .abort     (abort),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_stride(cfg_stride),
        .cmd_if    (cmd_if),
        .busy      (busy),
        .done      (done),
        .cur_iter  (cur_iter),
        .err_unexp (err_unexp),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         iters;
        logic [3:0] strides;
        logic       wr_cfg;
        int         pd;
        int         max_stall;
        int         stall_idx;
        int         stall_len;
        int         abort_mode;   // 0 none, 1 abort in WAIT, 2 abort while ISSUE is stalled
        int         abort_at;
        logic       poke;
        int         exp_cmds;
        int         exp_iter;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] exp_q[$];
    vec_t       vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected command words {phase, layer, stride} for a whole run.
    task automatic model_fill(input int iters, input logic [3:0] strides);
        logic [1:0] lay;
        exp_q.delete();
        for (int it = 0; it < iters; it++) begin
            for (int l = 0; l < L; l++) begin
                lay = 2'(l);
                exp_q.push_back({2'b01, lay, strides[l]});
            end
            for (int l = L - 1; l >= 0; l--) begin
                lay = 2'(l);
                exp_q.push_back({2'b10, lay, strides[l]});
                exp_q.push_back({2'b11, lay, strides[l]});
            end
        end
    endtask

    task automatic write_cfg(input logic [3:0] strides);
        for (int l = 0; l < L; l++) begin
            @(negedge clk);
            cfg_we     = 1'b1;
            cfg_addr   = 2'(l);
            cfg_stride = strides[l];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start    = 1'b1;
        iter_num = 8'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Acts as the PE FSM: accepts commands (with stalls), returns phase_done, injects aborts.
    task automatic run_pe(input vec_t v, output int n_cmds, output int n_done);
        int         stall_left;
        int         pd_cnt;
        int         post;
        logic       holding;
        logic       abort_next;
        logic [4:0] hold;
        logic [4:0] cur;
        logic [4:0] exp;
        n_cmds = 0; n_done = 0; stall_left = 0; pd_cnt = 0; post = -1;
        holding = 1'b0; abort_next = 1'b0; hold = '0;
        for (int cyc = 0; cyc < 4000 && post < 3; cyc++) begin
            @(negedge clk);
            cmd_if.cmd_ready  = 1'b0;
            cmd_if.phase_done = 1'b0;
            abort  = 1'b0;
            cfg_we = 1'b0;
            cur = {cmd_if.cmd_phase, cmd_if.cmd_layer, cmd_if.cmd_stride};
            if (done) begin
                n_done++;
                check("busy_low_at_done", int'(busy), 0);
                if (post < 0) post = 0;
            end else if (post >= 0) begin
                post++;
            end
            if (v.poke && cyc == 5) begin
                cfg_we     = 1'b1;
                cfg_addr   = 2'd1;
                cfg_stride = ~v.strides[1];
            end
            if (abort_next) begin
                abort             = 1'b1;
                cmd_if.phase_done = 1'b1;
                abort_next        = 1'b0;
                pd_cnt            = 0;
            end else if (pd_cnt > 0) begin
                pd_cnt--;
                if (pd_cnt == 0) cmd_if.phase_done = 1'b1;
            end
            if (holding && !cmd_if.cmd_valid) begin
                check("valid_dropped_without_ready", 0, 1);
                holding = 1'b0;
            end
            if (cmd_if.cmd_valid) begin
                if (!holding) begin
                    holding    = 1'b1;
                    hold       = cur;
                    stall_left = (n_cmds == v.stall_idx) ? v.stall_len
                                                          : int'($urandom_range(0, v.max_stall));
                    if (v.abort_mode == 2 && n_cmds == v.abort_at) stall_left = 4;
                end else begin
                    check("payload_stable", int'(cur), int'(hold));
                end
                if (v.abort_mode == 2 && n_cmds == v.abort_at && stall_left == 2) abort = 1'b1;
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    cmd_if.cmd_ready = 1'b1;
                    holding = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_extra_cmd", 1, 0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("cmd_payload", int'(cur), int'(exp));
                    end
                    if (v.abort_mode == 1 && n_cmds == v.abort_at) abort_next = 1'b1;
                    else if (!(v.abort_mode == 2 && n_cmds == v.abort_at)) pd_cnt = v.pd;
                    n_cmds++;
                end
            end
        end
        cmd_if.cmd_ready  = 1'b0;
        cmd_if.phase_done = 1'b0;
        abort  = 1'b0;
        cfg_we = 1'b0;
        if (post < 0) check("done_timeout", 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n_cmds;
        int n_done;
        if (v.wr_cfg) write_cfg(v.strides);
        model_fill(v.iters, v.strides);
        do_start(v.iters);
        run_pe(v, n_cmds, n_done);
        check({tag, "_cmd_count"}, n_cmds, v.exp_cmds);
        check({tag, "_done_pulses"}, n_done, 1);
        check({tag, "_cur_iter"}, int'(cur_iter), v.exp_iter);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_err_unexp"}, int'(err_unexp), 0);
        if (v.abort_mode == 0) check({tag, "_queue_drained"}, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        sch_rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_stride = 1'b0; iter_num = '0;
        cmd_if.cmd_ready = 1'b0; cmd_if.phase_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", int'(cmd_if.cmd_valid), 0);
        check("rst_cmd_phase", int'(cmd_if.cmd_phase), 0);
        check("rst_cmd_layer", int'(cmd_if.cmd_layer), 0);
        check("rst_cmd_stride", int'(cmd_if.cmd_stride), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cur_iter", int'(cur_iter), 0);
        check("rst_err_unexp", int'(err_unexp), 0);
        sch_rst = 1'b0;
        @(negedge clk);

        // phase_done while idle flags an error; the next start clears it.
        cmd_if.phase_done = 1'b1;
        @(negedge clk);
        cmd_if.phase_done = 1'b0;
        @(negedge clk);
        check("err_unexp_set_idle", int'(err_unexp), 1);
        check("err_busy_idle", int'(busy), 0);

        // Zero-iteration run: done two cycles after start, no command.
        do_start(0);
        check("zero_err_cleared", int'(err_unexp), 0);
        check("zero_busy_fin", int'(busy), 1);
        check("zero_done_early", int'(done), 0);
        check("zero_no_valid_1", int'(cmd_if.cmd_valid), 0);
        @(negedge clk);
        check("zero_done", int'(done), 1);
        check("zero_no_valid_2", int'(cmd_if.cmd_valid), 0);
        check("zero_cur_iter", int'(cur_iter), 0);
        @(negedge clk);
        check("zero_done_once", int'(done), 0);

        vecs.push_back('{1, 4'b1010, 1'b1, 3, 0, -1, 0, 0, 0,  1'b0, 12, 1});
        vecs.push_back('{3, 4'b1010, 1'b0, 2, 1, -1, 0, 0, 0,  1'b0, 36, 3});
        vecs.push_back('{1, 4'b0101, 1'b1, 2, 0,  1, 5, 0, 0,  1'b0, 12, 1});
        vecs.push_back('{2, 4'b0011, 1'b1, 2, 1, -1, 0, 1, 6,  1'b0,  7, 0});
        vecs.push_back('{1, 4'b1001, 1'b1, 3, 0, -1, 0, 2, 2,  1'b0,  3, 0});
        vecs.push_back('{2, 4'b0110, 1'b1, 1, 1, -1, 0, 1, 16, 1'b0, 17, 1});
        vecs.push_back('{2, 4'b1100, 1'b1, 2, 2, -1, 0, 0, 0,  1'b1, 24, 2});
        vecs.push_back('{1, 4'b1100, 1'b0, 1, 0, -1, 0, 0, 0,  1'b0, 12, 1});
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 6; r++) begin
            v.iters      = int'($urandom_range(1, 3));
            v.strides    = 4'($urandom_range(0, 15));
            v.wr_cfg     = 1'b1;
            v.pd         = int'($urandom_range(1, 4));
            v.max_stall  = int'($urandom_range(0, 3));
            v.stall_idx  = -1;
            v.stall_len  = 0;
            v.abort_mode = 0;
            v.abort_at   = 0;
            v.poke       = 1'($urandom_range(0, 1));
            v.exp_cmds   = 3 * L * v.iters;
            v.exp_iter   = v.iters;
            run_vec(v, $sformatf("rnd%0d", r));
        end

        // Reset mid-run returns everything, including the stride table, to zero.
        write_cfg(4'b1111);
        do_start(2);
        cmd_if.cmd_ready = 1'b1;
        repeat (4) @(negedge clk);
        sch_rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(cmd_if.cmd_valid), 0);
        check("midrst_cur_iter", int'(cur_iter), 0);
        @(negedge clk);
        sch_rst = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        run_vec('{1, 4'b0000, 1'b0, 2, 1, -1, 0, 0, 0, 1'b0, 12, 1}, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
